// File: rtl/video_pll_supervisor.sv
// rtl/video_pll_supervisor.sv - video PLL reset/lock bring-up sequencer with timeout retry and lock-loss recovery
// Optional lock-loss counter output enabled by defining VIDEO_PLL_LOSS_CNT_EN.
module video_pll_supervisor #(
  parameter int RST_HOLD_CYCLES = 64,
  parameter int LOCK_TIMEOUT    = 50000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRIES     = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pll_lock,
  input  logic        relock_req,
  output logic        pll_rst,
  output logic        video_rst_n,
  output logic        lock_ok,
  output logic        pll_fail,
  output logic [3:0]  retry_cnt,
  output logic [2:0]  sup_state
`ifdef VIDEO_PLL_LOSS_CNT_EN
  ,
  output logic [15:0] loss_cnt
`endif
);

  localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HOLD_END    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_END  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [3:0]      retry_n;
  logic            lock_m;
  logic            lock_s;

  assign sup_state = state;

  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    if (relock_req) begin
      state_n = S_HOLD;
      retry_n = 4'd0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_END) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (lock_s) begin
            state_n = S_STABLE;
          end else if (cnt == TIMEOUT_END) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_n = retry_cnt + 4'd1;
              state_n = S_HOLD;
            end else begin
              state_n = S_FAIL;
            end
          end
        end
        S_STABLE: begin
          // A dropout here is a glitch, so retries are not charged.
          if (!lock_s) begin
            state_n = S_WAIT;
          end else if (cnt == STABLE_END) begin
            state_n = S_RUN;
            retry_n = 4'd0;
          end
        end
        S_RUN: begin
          if (!lock_s) state_n = S_HOLD;
        end
        S_FAIL: begin
          state_n = S_FAIL;
        end
        default: begin
          state_n = S_HOLD;
        end
      endcase
    end
  end

  // RUN and FAIL have no terminal count, so the counter idles there instead of wrapping.
  always_comb begin
    cnt_n = cnt;
    if (relock_req || (state_n != state)) begin
      cnt_n = '0;
    end else if ((state != S_RUN) && (state != S_FAIL)) begin
      cnt_n = cnt + CW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      state       <= S_HOLD;
      cnt         <= '0;
      retry_cnt   <= 4'd0;
      pll_rst     <= 1'b1;
      video_rst_n <= 1'b0;
      lock_ok     <= 1'b0;
      pll_fail    <= 1'b0;
    end else begin
      lock_m      <= pll_lock;
      lock_s      <= lock_m;
      state       <= state_n;
      cnt         <= cnt_n;
      retry_cnt   <= retry_n;
      pll_rst     <= (state_n == S_HOLD) || (state_n == S_FAIL);
      video_rst_n <= (state_n == S_RUN);
      lock_ok     <= (state_n == S_RUN);
      pll_fail    <= (state_n == S_FAIL);
    end
  end

`ifdef VIDEO_PLL_LOSS_CNT_EN
  logic loss_evt;

  // Only genuine lock loss counts; a relock request in the same cycle takes precedence.
  assign loss_evt = (state == S_RUN) && !lock_s && !relock_req;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      loss_cnt <= 16'd0;
    end else if (loss_evt && (loss_cnt != 16'hFFFF)) begin
      loss_cnt <= loss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/video_pll_supervisor.md
Name: video_pll_supervisor

Overview:
- Sequences reset and lock bring-up of the video PLL; runs on the free-running 50 MHz board clock that also feeds the PLL input.
- Drives the PLL reset, qualifies the asynchronous PLL lock, retries on lock timeout, releases the video-domain reset only after lock has been stable.
- Detects lock loss during operation and re-runs the sequence automatically.

Parameters:
- RST_HOLD_CYCLES, 64, cycles pll_rst is held high per attempt (≥2)
- LOCK_TIMEOUT, 50000, cycles allowed from pll_rst release to synchronized lock before retry (1 ms @ 50 MHz)
- STABLE_CYCLES, 1024, consecutive cycles of synchronized lock required before release
- MAX_RETRIES, 3, timed-out attempts tolerated before FAIL (1..15)

Ports:
- sys_clk  in  1  free-running 50 MHz reference clock
- sys_rst_n  in  1  synchronous active-low reset
- pll_lock  in  1  raw PLL lock, asynchronous to sys_clk
- relock_req  in  1  one-cycle pulse; forces a fresh bring-up from any state
- pll_rst  out  1  reset to PLL, active-high
- video_rst_n  out  1  active-low reset for video logic, deasserted only in RUN
- lock_ok  out  1  high in RUN
- pll_fail  out  1  high in FAIL
- retry_cnt  out  4  timed-out attempts in current bring-up
- sup_state  out  3  current state encoding

Behaviour:
- pll_lock passes through a 2-flop synchronizer (lock_s); all decisions use lock_s, giving 2 cycles of input latency.
- States and encoding: HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4. One shared counter, cleared on every state entry.
- Reset (sys_rst_n=0 at a sys_clk edge): state=HOLD, counter=0, retry_cnt=0, pll_rst=1, video_rst_n=0, lock_ok=0, pll_fail=0, synchronizer flops=0.
- HOLD: pll_rst=1. After RST_HOLD_CYCLES cycles in HOLD, go to WAIT. pll_rst goes low on the first WAIT cycle.
- WAIT: pll_rst=0.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT-1 without lock: if retry_cnt < MAX_RETRIES, increment retry_cnt and go to HOLD; otherwise go to FAIL.
- STABLE:
  - lock_s=0 on any cycle: return to WAIT with the counter restarted. retry_cnt is unchanged; this is a glitch, not a timeout.
  - STABLE_CYCLES consecutive lock_s=1 cycles: go to RUN.
- RUN: video_rst_n=1, lock_ok=1, retry_cnt cleared to 0 on entry.
  - lock_s=0 for one cycle means lock loss: go to HOLD. video_rst_n=0 and lock_ok=0 on the same edge as the state change.
- FAIL: pll_rst=1, pll_fail=1, video_rst_n=0. Exits only on relock_req or sys_rst_n.
- relock_req:
  - Valid in any state; it takes priority over every other transition in that cycle.
  - Go to HOLD with counter=0, retry_cnt=0, pll_fail=0.
  - A relock_req arriving while already in HOLD restarts the hold count.
- All outputs are registered: video_rst_n rises on the first RUN cycle and falls on the first cycle after leaving RUN.
- Counters are wide enough for the largest parameter, computed with $clog2. No wrap: the counter never exceeds its terminal value, because the transition happens at that value.
- pll_rst is never low while in HOLD or FAIL; video_rst_n is never high outside RUN.

Optional Feature:
- Macro: VIDEO_PLL_LOSS_CNT_EN.
- Defined:
  - Adds output loss_cnt[15:0], a count of RUN→HOLD transitions caused by lock loss.
  - Saturates at 16'hFFFF; cleared only by sys_rst_n, not by relock_req.
  - Reset value 0.
- Undefined: no such port and no counter logic.

Test Plan:
- Reset release, pll_lock rises 100 cycles after pll_rst falls → pll_rst high exactly 64 cycles; RUN reached 2+1024(+1 state) cycles after lock rise; video_rst_n=1, retry_cnt=0.
- pll_lock held 0 (LOCK_TIMEOUT reduced to 200) → three HOLD/WAIT retries with retry_cnt 1,2,3; on the 4th timeout pll_fail=1 and pll_rst=1; relock_req pulse → HOLD, pll_fail=0, retry_cnt=0.
- Lock glitch: lock drops for 3 cycles at STABLE count 500 → back to WAIT, retry_cnt unchanged; a later stable lock of 1024 cycles reaches RUN.
- Lock loss in RUN: pll_lock drops 1 cycle → video_rst_n falls 3 cycles later (2 sync + 1); pll_rst high for 64 cycles; loss_cnt=1 when the macro is defined.
- relock_req asserted in the same cycle as the STABLE→RUN condition → HOLD wins; video_rst_n stays 0.
- sys_rst_n asserted mid-RUN → next edge restores all reset values (pll_rst=1, video_rst_n=0, state=0); with the macro defined, loss_cnt=0.
